lego_fpga_kvs_pcie: RTL and testbench

Single-clock key-value store engine behind the PCIe AXI-Stream host channel. Accepts GET/SET/DEL request packets on a 256-bit RX stream and returns one response packet per request on a 256-bit TX stream. Backing store is an on-chip direct-mapped table of 64-bit keys and 256-bit values. It replaces the DDR4-backed KVS datapath for host-link bring-up.

---
 rtl/lego_fpga_kvs_pcie.sv | 200 ++++++++++++++++++++
 tb/tb_lego_fpga_kvs_pcie.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lego_fpga_kvs_pcie.sv
// Key-value store engine on a 256-bit AXI-Stream host channel, backed by an on-chip direct-mapped table.
// Optional request/response counters are enabled by defining KVS_STATS_EN.
module lego_fpga_kvs_pcie #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic         clk_150,
    input  logic         sys_rst,
    input  logic         driver_ready,
    output logic         init_done,
    input  logic [255:0] RX_tdata,
    input  logic [31:0]  RX_tkeep,
    input  logic [63:0]  RX_tuser,
    input  logic         RX_tvalid,
    input  logic         RX_tlast,
    output logic         RX_tready,
    output logic [255:0] TX_tdata,
    output logic [31:0]  TX_tkeep,
    output logic [63:0]  TX_tuser,
    output logic         TX_tvalid,
    output logic         TX_tlast,
    input  logic         TX_tready
`ifdef KVS_STATS_EN
    ,
    output logic [31:0]  nr_req,
    output logic [31:0]  nr_resp
`endif
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [7:0]  OP_GET = 8'h01;
    localparam logic [7:0]  OP_SET = 8'h02;
    localparam logic [7:0]  OP_DEL = 8'h03;
    localparam logic [7:0]  ST_OK   = 8'h00;
    localparam logic [7:0]  ST_MISS = 8'h01;
    localparam logic [7:0]  ST_BAD  = 8'h02;

    typedef enum logic [2:0] {
        StInit, StIdle, StRdVal, StDrain, StLookup, StRespHdr, StRespVal
    } state_e;

    state_e state_q, state_d;
    logic   tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0] init_idx_q;

    logic          mem_valid [DEPTH];
    logic [63:0]   mem_key   [DEPTH];
    logic [255:0]  mem_val   [DEPTH];

    logic [7:0]   op_q, status_q;
    logic [15:0]  id_q;
    logic [63:0]  key_q, user_q, rd_key_q;
    logic [255:0] val_q, rd_val_q;
    logic         bad_q, has_val_q, rd_valid_q;

    logic [7:0]        hdr_op;
    logic              hdr_bad, rx_fire, hit;
    logic [ADDR_W-1:0] rd_idx, key_idx;
    logic [7:0]        lk_status;
    logic              lk_has_val, wr_en, wr_valid;
    logic              unused_bits;

    assign hdr_op  = RX_tdata[7:0];
    assign hdr_bad = !(hdr_op == OP_GET || hdr_op == OP_SET || hdr_op == OP_DEL)
                     || (hdr_op == OP_SET && RX_tlast);
    assign rx_fire = RX_tvalid && RX_tready;
    assign key_idx = key_q[ADDR_W-1:0];
    // In IDLE the read is steered by the incoming key so the entry is ready by LOOKUP
    assign rd_idx  = (state_q == StIdle) ? RX_tdata[32 +: ADDR_W] : key_idx;
    assign hit     = rd_valid_q && (rd_key_q == key_q);
    assign unused_bits = ^{RX_tkeep, RX_tdata[255:96], RX_tdata[15:8]};

    always_ff @(posedge clk_150) begin
        if (sys_rst) begin
            state_q    <= StInit;
            tx_valid_q <= 1'b0;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            if (state_q == StInit) init_idx_q <= init_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_valid_d = 1'b0;
        case (state_q)
            StInit:   if (init_idx_q == '1) state_d = StIdle;
            StIdle: begin
                if (rx_fire) begin
                    if (!hdr_bad && hdr_op == OP_SET) state_d = StRdVal;
                    else if (RX_tlast)                state_d = StLookup;
                    else                              state_d = StDrain;
                end
            end
            StRdVal:  if (rx_fire) state_d = RX_tlast ? StLookup : StDrain;
            StDrain:  if (rx_fire && RX_tlast) state_d = StLookup;
            StLookup: state_d = StRespHdr;
            StRespHdr: begin
                if (!tx_valid_q)     tx_valid_d = driver_ready;
                else if (!TX_tready) tx_valid_d = 1'b1;
                else begin
                    state_d    = has_val_q ? StRespVal : StIdle;
                    tx_valid_d = has_val_q && driver_ready;
                end
            end
            StRespVal: begin
                if (!tx_valid_q)     tx_valid_d = driver_ready;
                else if (!TX_tready) tx_valid_d = 1'b1;
                else                 state_d    = StIdle;
            end
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        lk_status  = ST_OK;
        lk_has_val = 1'b0;
        wr_en      = 1'b0;
        wr_valid   = (op_q == OP_SET);
        if (bad_q) begin
            lk_status = ST_BAD;
        end else begin
            case (op_q)
                OP_GET: begin
                    lk_status  = hit ? ST_OK : ST_MISS;
                    lk_has_val = hit;
                end
                OP_SET: wr_en = 1'b1;
                OP_DEL: begin
                    lk_status = hit ? ST_OK : ST_MISS;
                    wr_en     = hit;
                end
                default: lk_status = ST_BAD;
            endcase
        end
    end

    always_ff @(posedge clk_150) begin
        if (state_q == StIdle && rx_fire) begin
            op_q   <= hdr_op;
            id_q   <= RX_tdata[31:16];
            key_q  <= RX_tdata[95:32];
            user_q <= RX_tuser;
            bad_q  <= hdr_bad;
        end
        if (state_q == StRdVal && rx_fire) val_q <= RX_tdata;
        // Read data is frozen once the request is complete so the value beat stays stable
        if (state_q == StIdle || state_q == StRdVal || state_q == StDrain) begin
            rd_valid_q <= mem_valid[rd_idx];
            rd_key_q   <= mem_key[rd_idx];
            rd_val_q   <= mem_val[rd_idx];
        end
        if (state_q == StLookup) begin
            status_q  <= lk_status;
            has_val_q <= lk_has_val;
        end
    end

    always_ff @(posedge clk_150) begin
        if (!sys_rst) begin
            if (state_q == StInit) begin
                mem_valid[init_idx_q] <= 1'b0;
            end else if (state_q == StLookup && wr_en) begin
                mem_valid[key_idx] <= wr_valid;
                if (wr_valid) begin
                    mem_key[key_idx] <= key_q;
                    mem_val[key_idx] <= val_q;
                end
            end
        end
    end

    always_comb begin
        init_done = (state_q != StInit);
        RX_tready = (state_q == StIdle) || (state_q == StRdVal) || (state_q == StDrain);
        TX_tvalid = tx_valid_q;
        TX_tkeep  = tx_valid_q ? 32'hFFFF_FFFF : 32'h0;
        TX_tuser  = tx_valid_q ? user_q : 64'h0;
        TX_tlast  = tx_valid_q && (state_q == StRespVal || !has_val_q);
        TX_tdata  = '0;
        if (tx_valid_q) begin
            TX_tdata = (state_q == StRespVal) ? rd_val_q
                                              : {160'h0, key_q, id_q, status_q, op_q};
        end
    end

`ifdef KVS_STATS_EN
    always_ff @(posedge clk_150) begin
        if (sys_rst) begin
            nr_req  <= '0;
            nr_resp <= '0;
        end else begin
            if (state_q == StIdle && rx_fire) nr_req <= nr_req + 32'd1;
            if (TX_tvalid && TX_tready && TX_tlast) nr_resp <= nr_resp + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lego_fpga_kvs_pcie.sv
// Self-checking bench for lego_fpga_kvs_pcie: directed scenarios plus randomized traffic
// compared against a table model indexed by key modulo the table size.
module tb_lego_fpga_kvs_pcie;

    localparam int DEPTH = 1024;

    logic         clk_150 = 1'b0;
    logic         sys_rst;
    logic         driver_ready;
    logic         init_done;
    logic [255:0] RX_tdata;
    logic [31:0]  RX_tkeep;
    logic [63:0]  RX_tuser;
    logic         RX_tvalid;
    logic         RX_tlast;
    logic         RX_tready;
    logic [255:0] TX_tdata;
    logic [31:0]  TX_tkeep;
    logic [63:0]  TX_tuser;
    logic         TX_tvalid;
    logic         TX_tlast;
    logic         TX_tready;

    always #5 clk_150 = ~clk_150;

    lego_fpga_kvs_pcie #(.ADDR_W(10)) dut (
        .clk_150      (clk_150),
        .sys_rst      (sys_rst),
        .driver_ready (driver_ready),
        .init_done    (init_done),
        .RX_tdata     (RX_tdata),
        .RX_tkeep     (RX_tkeep),
        .RX_tuser     (RX_tuser),
        .RX_tvalid    (RX_tvalid),
        .RX_tlast     (RX_tlast),
        .RX_tready    (RX_tready),
        .TX_tdata     (TX_tdata),
        .TX_tkeep     (TX_tkeep),
        .TX_tuser     (TX_tuser),
        .TX_tvalid    (TX_tvalid),
        .TX_tlast     (TX_tlast),
        .TX_tready    (TX_tready)
    );

    int checks   = 0;
    int failures = 0;

    bit           m_valid [DEPTH];
    logic [63:0]  m_key   [DEPTH];
    logic [255:0] m_val   [DEPTH];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic abort(input string tag);
        failures++;
        $display("FAIL %s observed=timeout expected=handshake", tag);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench stopped");
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] mk_hdr(input logic [7:0] op, input logic [15:0] id,
                                            input logic [63:0] key);
        logic [255:0] h;
        h = rnd256();
        h[7:0]   = op;
        h[31:16] = id;
        h[95:32] = key;
        return h;
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic last);
        int w;
        w = 0;
        RX_tdata  = d;
        RX_tlast  = last;
        RX_tkeep  = $urandom;
        RX_tvalid = 1'b1;
        while (1) begin
            @(negedge clk_150);
            if (RX_tready) break;
            w++;
            if (w > 3000) abort("rx_accept");
        end
        @(posedge clk_150);
        #1;
        RX_tvalid = 1'b0;
        RX_tlast  = 1'b0;
    endtask

    task automatic recv(input bit stall, output logic [255:0] h, output logic [255:0] v,
                        output logic [63:0] u, output int n, output int lat, output bit last);
        bit done;
        int g;
        h = '0; v = '0; u = '0; n = 0; lat = 0; last = 0; done = 0; g = 0;
        while (1) begin
            @(negedge clk_150);
            if (TX_tvalid) break;
            if (lat >= 100) abort("tx_valid_wait");
            @(posedge clk_150);
            lat++;
        end
        while (1) begin
            if (TX_tvalid) begin
                TX_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (TX_tready) begin
                    chk("tx_tkeep", {224'h0, TX_tkeep}, {224'h0, 32'hFFFF_FFFF});
                    if (n == 0) begin
                        h = TX_tdata;
                        u = TX_tuser;
                    end else begin
                        v = TX_tdata;
                    end
                    n++;
                    last = TX_tlast;
                    done = TX_tlast || (n >= 2);
                end
            end else begin
                TX_tready = 1'b0;
            end
            @(posedge clk_150);
            if (done) break;
            g++;
            if (g > 300) abort("tx_resp_wait");
            @(negedge clk_150);
        end
        #1;
        TX_tready = 1'b0;
    endtask

    // One request/response exchange, checked against the table model, which is then updated
    task automatic transact(input logic [7:0] op, input logic [63:0] key, input logic [255:0] val,
                            input bit set_short, input int extra, input bit stall,
                            output logic [7:0] st, output logic [255:0] v_obs);
        logic [15:0]  id;
        logic [63:0]  user, u;
        logic [255:0] hdr, h, v;
        logic [7:0]   exp_st;
        int idx, nb, n, lat, exp_n, ext;
        bit hit, bad, last;
        id   = 16'($urandom);
        user = {$urandom, $urandom};
        idx  = int'(key % 64'd1024);
        hit  = m_valid[idx] && (m_key[idx] == key);
        bad  = !(op == 8'h01 || op == 8'h02 || op == 8'h03) || (op == 8'h02 && set_short);
        if (bad)               exp_st = 8'h02;
        else if (op == 8'h02)  exp_st = 8'h00;
        else                   exp_st = hit ? 8'h00 : 8'h01;
        exp_n = (!bad && op == 8'h01 && hit) ? 2 : 1;
        ext   = set_short ? 0 : extra;
        nb    = 1 + ((op == 8'h02 && !set_short) ? 1 : 0) + ext;
        hdr   = mk_hdr(op, id, key);
        RX_tuser = user;
        for (int i = 0; i < nb; i++) begin
            if (i == 0)                          send_beat(hdr, nb == 1);
            else if (i == 1 && op == 8'h02 && !bad) send_beat(val, nb == 2);
            else                                 send_beat(rnd256(), i == nb - 1);
            RX_tuser = {$urandom, $urandom};
        end
        recv(stall, h, v, u, n, lat, last);
        chk("resp_latency", 256'(lat), 256'd2);
        chk("resp_beats", 256'(n), 256'(exp_n));
        chk("resp_tlast", {255'h0, last}, 256'd1);
        chk("resp_header", h, {160'h0, key, id, exp_st, op});
        chk("resp_tuser", {192'h0, u}, {192'h0, user});
        if (exp_n == 2) chk("resp_value", v, m_val[idx]);
        if (!bad && op == 8'h02) begin
            m_valid[idx] = 1'b1;
            m_key[idx]   = key;
            m_val[idx]   = val;
        end else if (!bad && op == 8'h03 && hit) begin
            m_valid[idx] = 1'b0;
        end
        st    = h[15:8];
        v_obs = v;
    endtask

    task automatic do_reset();
        int n;
        bit rdy_seen;
        sys_rst   = 1'b1;
        RX_tvalid = 1'b0;
        RX_tlast  = 1'b0;
        TX_tready = 1'b0;
        repeat (2) @(posedge clk_150);
        #1;
        chk("rst_outputs", {251'h0, RX_tready, TX_tvalid, TX_tlast, init_done, 1'b0},
            256'h0);
        chk("rst_tdata", TX_tdata, 256'h0);
        chk("rst_tuser", {192'h0, TX_tuser}, 256'h0);
        sys_rst  = 1'b0;
        n        = 0;
        rdy_seen = 0;
        while (1) begin
            @(negedge clk_150);
            if (init_done) break;
            if (RX_tready) rdy_seen = 1;
            if (n > 2000) abort("init_done_wait");
            @(posedge clk_150);
            n++;
        end
        @(posedge clk_150);
        #1;
        chk("init_cycles", 256'(n), 256'd1024);
        chk("init_rx_tready", {255'h0, rdy_seen}, 256'h0);
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        logic [7:0]   st;
        logic [255:0] v, h, first, val_b;
        logic [63:0]  u, k;
        logic [63:0]  pool [8];
        int n, lat, w;
        bit last, stable, rdy_seen, valid_seen;

        driver_ready = 1'b1;
        RX_tdata = '0; RX_tkeep = '0; RX_tuser = '0;
        do_reset();

        transact(8'h02, 64'h0000_0000_DEAD_BEEF, {32{8'hA5}}, 0, 0, 0, st, v);
        chk("set_status", {248'h0, st}, 256'h00);
        transact(8'h01, 64'h0000_0000_DEAD_BEEF, '0, 0, 0, 0, st, v);
        chk("get_hit_status", {248'h0, st}, 256'h00);
        chk("get_hit_value", v, {32{8'hA5}});
        transact(8'h01, 64'h1234, '0, 0, 0, 0, st, v);
        chk("get_empty_status", {248'h0, st}, 256'h01);
        transact(8'h03, 64'h0000_0000_DEAD_BEEF, '0, 0, 0, 0, st, v);
        chk("del_hit_status", {248'h0, st}, 256'h00);
        transact(8'h01, 64'h0000_0000_DEAD_BEEF, '0, 0, 0, 0, st, v);
        chk("get_after_del", {248'h0, st}, 256'h01);

        transact(8'h02, 64'h400, rnd256(), 0, 0, 0, st, v);
        transact(8'h02, 64'h800, rnd256(), 0, 0, 0, st, v);
        transact(8'h01, 64'h400, '0, 0, 0, 0, st, v);
        chk("collision_evicted", {248'h0, st}, 256'h01);
        transact(8'h01, 64'h800, '0, 0, 0, 0, st, v);
        chk("collision_hit", {248'h0, st}, 256'h00);

        // Backpressure on a GET hit: header must hold for 20 stalled cycles
        val_b = rnd256();
        transact(8'h02, 64'h55, val_b, 0, 0, 0, st, v);
        RX_tuser = 64'h1111_2222_3333_4444;
        send_beat(mk_hdr(8'h01, 16'hBEEF, 64'h55), 1'b1);
        w = 0;
        while (1) begin
            @(negedge clk_150);
            if (TX_tvalid) break;
            if (w > 100) abort("bp_valid_wait");
            @(posedge clk_150);
            w++;
        end
        first    = TX_tdata;
        stable   = 1;
        rdy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_150);
            @(negedge clk_150);
            if (TX_tdata !== first || TX_tvalid !== 1'b1 || TX_tlast !== 1'b0) stable = 0;
            if (RX_tready) rdy_seen = 1;
        end
        @(posedge clk_150);
        #1;
        recv(0, h, v, u, n, lat, last);
        chk("bp_stable", {255'h0, stable}, 256'd1);
        chk("bp_rx_tready", {255'h0, rdy_seen}, 256'h0);
        chk("bp_beats", 256'(n), 256'd2);
        chk("bp_header", h, {160'h0, 64'h55, 16'hBEEF, 8'h00, 8'h01});
        chk("bp_value", v, val_b);
        chk("bp_tuser", {192'h0, u}, {192'h0, 64'h1111_2222_3333_4444});

        // driver_ready low holds off TX_tvalid
        driver_ready = 1'b0;
        send_beat(mk_hdr(8'h01, 16'h0007, 64'h1234), 1'b1);
        valid_seen = 0;
        repeat (15) begin
            @(negedge clk_150);
            if (TX_tvalid) valid_seen = 1;
            @(posedge clk_150);
        end
        #1;
        driver_ready = 1'b1;
        recv(0, h, v, u, n, lat, last);
        chk("drv_ready_hold", {255'h0, valid_seen}, 256'h0);
        chk("drv_ready_header", h, {160'h0, 64'h1234, 16'h0007, 8'h01, 8'h01});

        transact(8'h7F, 64'h99, '0, 0, 0, 0, st, v);
        chk("bad_opcode", {248'h0, st}, 256'h02);
        transact(8'h02, 64'h77, rnd256(), 1, 0, 0, st, v);
        chk("set_short", {248'h0, st}, 256'h02);
        transact(8'h01, 64'h55, '0, 0, 3, 0, st, v);
        chk("get_4beat", {248'h0, st}, 256'h00);
        transact(8'h01, 64'h800, '0, 0, 0, 0, st, v);
        chk("after_drain", {248'h0, st}, 256'h00);

        // Reset in the middle of a SET wipes the table
        transact(8'h02, 64'hCAFE, rnd256(), 0, 0, 0, st, v);
        RX_tuser = '0;
        send_beat(mk_hdr(8'h02, 16'h0042, 64'hCAFE), 1'b0);
        do_reset();
        transact(8'h01, 64'hCAFE, '0, 0, 0, 0, st, v);
        chk("get_after_reset", {248'h0, st}, 256'h01);

        for (int i = 0; i < 8; i++) begin
            k = {$urandom, $urandom};
            k[9:0] = (i < 4) ? 10'h005 : 10'h006;
            pool[i] = k;
        end
        for (int t = 0; t < 150; t++) begin
            logic [7:0] op;
            int r, extra;
            bit sh;
            r = $urandom_range(0, 9);
            if (r <= 3)      op = 8'h02;
            else if (r <= 6) op = 8'h01;
            else if (r <= 8) op = 8'h03;
            else begin
                case ($urandom_range(0, 3))
                    0:       op = 8'h00;
                    1:       op = 8'h04;
                    2:       op = 8'h7F;
                    default: op = 8'hFF;
                endcase
            end
            sh    = (op == 8'h02) && ($urandom_range(0, 9) == 0);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            transact(op, pool[$urandom_range(0, 7)], rnd256(), sh, extra,
                     bit'($urandom_range(0, 1)), st, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
